// File: rtl/timer_defs_pkg.sv
// timer_defs: shared constants, mode encoding and digit clamp helper for the
// game timer and its BCD stages.
package timer_defs;

   localparam int unsigned DIGIT_W       = 4;
   localparam logic [3:0]  UNITS_MAX     = 4'd9;
   localparam int unsigned TENS_MAX_DFLT = 5;

   typedef enum logic {
      DOWN = 1'b0,
      UP   = 1'b1
   } mode_e;

   // Saturate an out-of-range BCD digit to its legal maximum.
   function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d,
                                                      input logic [DIGIT_W-1:0] lim);
      return (d > lim) ? lim : d;
   endfunction

endpackage

// File: rtl/game_timer_bcd_stage.sv
// bcd_stage: one BCD digit pair (units 0..9, tens 0..TENS_MAX) with up/down
// stepping, clamped synchronous load and combinational carry/borrow out.
//   clk, reset      : clock, asynchronous active-high reset
//   step_in         : advance this stage by one this cycle
//   up_dn           : 1 = up, 0 = down
//   load, load_val  : preload {tens, units}, priority over step_in
//   units, tens     : current digits
//   step_out        : carry (up) or borrow (down) into the next stage
//   is_zero         : both digits are zero
module bcd_stage
   import timer_defs::*;
#(
   parameter int unsigned TENS_MAX = TENS_MAX_DFLT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       step_in,
   input  logic       up_dn,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [3:0] units,
   output logic [3:0] tens,
   output logic       step_out,
   output logic       is_zero
);

   localparam logic [3:0] TensLim = 4'(TENS_MAX);

   logic [3:0] r_units;
   logic [3:0] r_tens;
   logic       w_up;
   logic       w_units_max;
   logic       w_tens_max;
   logic       w_units_min;
   logic       w_tens_min;

   assign w_up        = (up_dn == UP);
   assign w_units_max = (r_units == UNITS_MAX);
   assign w_tens_max  = (r_tens == TensLim);
   assign w_units_min = (r_units == 4'd0);
   assign w_tens_min  = (r_tens == 4'd0);

   // Carry/borrow ripples combinationally so the whole chain steps in one cycle.
   assign step_out = step_in & (w_up ? (w_units_max & w_tens_max)
                                     : (w_units_min & w_tens_min));
   assign is_zero  = w_units_min & w_tens_min;
   assign units    = r_units;
   assign tens     = r_tens;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_units <= 4'd0;
         r_tens  <= 4'd0;
      end else if (load) begin
         r_units <= clamp_digit(load_val[3:0], UNITS_MAX);
         r_tens  <= clamp_digit(load_val[7:4], TensLim);
      end else if (step_in) begin
         if (w_up) begin
            if (w_units_max) begin
               r_units <= 4'd0;
               r_tens  <= w_tens_max ? 4'd0 : r_tens + 4'd1;
            end else begin
               r_units <= r_units + 4'd1;
            end
         end else begin
            if (w_units_min) begin
               r_units <= UNITS_MAX;
               r_tens  <= w_tens_min ? TensLim : r_tens - 4'd1;
            end else begin
               r_units <= r_units - 4'd1;
            end
         end
      end
   end

endmodule

// File: rtl/game_timer.sv
// game_timer: prescaled multi-stage BCD up/down timer with pause and preload.
//   clk, reset : clock, asynchronous active-high reset
//   en         : run enable (0 pauses prescaler and digits)
//   up_dn      : 1 = count up, 0 = count down
//   load       : synchronous preload of load_val (clamped BCD)
//   digits     : current count, stage 0 in [7:0]
//   tick       : registered pulse, first cycle a stepped value is visible
//   wrap       : registered pulse when an up step rolls max -> zero
//   done       : registered pulse when a down step reaches zero
//   zero       : level, digits all zero
module game_timer
   import timer_defs::*;
#(
   parameter int unsigned STAGES       = 2,
   parameter int unsigned TOP_TENS_MAX = 9,
   parameter int unsigned TICK_DIV     = 100_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic                up_dn,
   input  logic                load,
   input  logic [8*STAGES-1:0] load_val,
   output logic [8*STAGES-1:0] digits,
   output logic                tick,
   output logic                wrap,
   output logic                done,
   output logic                zero
);

   localparam int unsigned     PRE_W   = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PreLast = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0]    r_pre;
   logic                r_tick;
   logic                r_wrap;
   logic                r_done;
   logic [8*STAGES-1:0] w_digits;
   logic [STAGES-1:0]   w_is_zero;
   logic [STAGES:0]     w_carry;
   logic                w_step_evt;
   logic                w_step;
   logic                w_zero;
   logic                w_one;
   logic                w_down;

   assign w_zero     = &w_is_zero;
   assign w_one      = (w_digits == (8*STAGES)'(1));
   assign w_down     = (up_dn == DOWN);
   assign w_step_evt = en & (r_pre == PreLast);
   // Down steps from all-zero are swallowed so the count saturates; load wins.
   assign w_step     = w_step_evt & ~load & ~(w_down & w_zero);
   assign w_carry[0] = w_step;

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      localparam int unsigned TensMax = (i == STAGES - 1) ? TOP_TENS_MAX : TENS_MAX_DFLT;
      bcd_stage #(
         .TENS_MAX(TensMax)
      ) u_stage (
         .clk     (clk),
         .reset   (reset),
         .step_in (w_carry[i]),
         .up_dn   (up_dn),
         .load    (load),
         .load_val(load_val[8*i +: 8]),
         .units   (w_digits[8*i +: 4]),
         .tens    (w_digits[8*i+4 +: 4]),
         .step_out(w_carry[i+1]),
         .is_zero (w_is_zero[i])
      );
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pre  <= '0;
         r_tick <= 1'b0;
         r_wrap <= 1'b0;
         r_done <= 1'b0;
      end else begin
         if (load) begin
            r_pre <= '0;
         end else if (en) begin
            r_pre <= w_step_evt ? '0 : r_pre + 1'b1;
         end
         r_tick <= w_step;
         r_wrap <= w_carry[STAGES] & ~w_down;
         // Value 1 stepped down lands on zero.
         r_done <= w_step & w_down & w_one;
      end
   end

   assign digits = w_digits;
   assign tick   = r_tick;
   assign wrap   = r_wrap;
   assign done   = r_done;
   assign zero   = w_zero;

endmodule

// File: tb/tb_game_timer.sv
module tb_game_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        en;
   logic        up_dn;
   logic        load;
   logic [15:0] load_val;
   logic [15:0] digits, digits5;
   logic        tick, wrap, done, zero;
   logic        tick5, wrap5, done5, zero5;

   int n_total = 0;
   int n_pass  = 0;
   int cyc     = 0;

   typedef struct {
      int          cyc;
      logic [15:0] digits;
      logic        wrap;
      logic        done;
      logic        zero;
   } exp_t;

   exp_t q[$];

   game_timer #(.STAGES(2), .TOP_TENS_MAX(9), .TICK_DIV(4)) dut (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .digits(digits), .tick(tick), .wrap(wrap), .done(done), .zero(zero)
   );

   game_timer #(.STAGES(2), .TOP_TENS_MAX(5), .TICK_DIV(4)) dut5 (
      .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load), .load_val(load_val),
      .digits(digits5), .tick(tick5), .wrap(wrap5), .done(done5), .zero(zero5)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int c, input logic [15:0] d, input logic w, input logic dn,
                       input logic z);
      exp_t e;
      e.cyc = c; e.digits = d; e.wrap = w; e.done = dn; e.zero = z;
      q.push_back(e);
   endtask

   // Load with en low, then enable; returns the first enabled cycle.
   task automatic load_start(input logic [15:0] val, input logic up, output int s);
      load = 1'b1; load_val = val; en = 1'b0; up_dn = up;
      cycles(1);
      load = 1'b0;
      chk("load_digits", digits, val);
      chk("load_no_tick", tick, 1'b0);
      en = 1'b1;
      s  = cyc;
   endtask

   // Monitor: every tick pops one expected record.
   always @(negedge clk) begin
      if (!reset) begin
         if (tick) begin
            if (q.size() == 0) begin
               chk("unexpected_tick", 1'b1, 1'b0);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("tick_cycle", cyc, e.cyc);
               chk("tick_digits", digits, e.digits);
               chk("tick_wrap", wrap, e.wrap);
               chk("tick_done", done, e.done);
               chk("tick_zero", zero, e.zero);
            end
         end else begin
            chk("idle_wrap_done", {wrap, done}, 2'b00);
         end
      end
   end

   initial begin
      int s;
      reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
      cycles(3);
      chk("rst_digits", digits, 16'h0000);
      chk("rst_zero", zero, 1'b1);
      chk("rst_pulses", {tick, wrap, done}, 3'b000);

      // Free-run up for 40 cycles: ticks every 4th cycle, first in cycle 5.
      reset = 1'b0; en = 1'b1; up_dn = 1'b1;
      s = cyc;
      for (int k = 1; k <= 10; k++) begin
         logic [15:0] d;
         d = {8'h00, 4'(k / 10), 4'(k % 10)};
         push(s + 4 * k, d, 1'b0, 1'b0, 1'b0);
      end
      cycles(40);
      en = 1'b0;
      chk("run40_digits", digits, 16'h0010);
      cycles(1);
      chk("run40_drained", q.size(), 0);

      // Up wrap from the full count.
      load_start(16'h9959, 1'b1, s);
      push(s + 4, 16'h0000, 1'b1, 1'b0, 1'b1);
      cycles(5);
      chk("wrap_drained", q.size(), 0);

      // Down with borrow across stages.
      load_start(16'h0100, 1'b0, s);
      push(s + 4, 16'h0059, 1'b0, 1'b0, 1'b0);
      push(s + 8, 16'h0058, 1'b0, 1'b0, 1'b0);
      cycles(9);
      chk("borrow_drained", q.size(), 0);

      // Down to zero, then three suppressed step periods.
      load_start(16'h0001, 1'b0, s);
      push(s + 4, 16'h0000, 1'b0, 1'b1, 1'b1);
      cycles(17);
      chk("sat_digits", digits, 16'h0000);
      chk("sat_zero", zero, 1'b1);
      chk("sat_drained", q.size(), 0);

      // Pause with pre=2 for 10 cycles; step lands 2 cycles after re-enable.
      load_start(16'h0000, 1'b1, s);
      cycles(2);
      en = 1'b0;
      cycles(10);
      en = 1'b1;
      push(s + 14, 16'h0001, 1'b0, 1'b0, 1'b0);
      cycles(5);
      // Cycle s+17 is a step cycle; load must win and suppress the tick.
      load = 1'b1; load_val = 16'h0130;
      cycles(1);
      load = 1'b0;
      chk("ldstep_digits", digits, 16'h0130);
      chk("ldstep_no_tick", tick, 1'b0);
      push(s + 22, 16'h0131, 1'b0, 1'b0, 1'b0);
      cycles(5);
      chk("pause_drained", q.size(), 0);

      // Clamping; stage 0 tens 3 is legal and passes unchanged.
      en = 1'b0; load = 1'b1; load_val = 16'h7F3C;
      cycles(1);
      chk("clamp9_a", digits, 16'h7939);
      chk("clamp5_a", digits5, 16'h5939);
      load_val = 16'h7F7C;
      cycles(1);
      load = 1'b0;
      chk("clamp9_b", digits, 16'h7959);
      chk("clamp5_b", digits5, 16'h5959);

      // Asynchronous reset mid-period.
      en = 1'b1; up_dn = 1'b1;
      cycles(2);
      #2 reset = 1'b1;
      #1;
      chk("arst_digits", digits, 16'h0000);
      chk("arst_digits5", digits5, 16'h0000);
      chk("arst_zero", zero, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      s = cyc;
      push(s + 4, 16'h0001, 1'b0, 1'b0, 1'b0);
      cycles(5);
      chk("final_drained", q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
